// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared definitions for the instruction fetch slice: bus
//               width, enable/disable levels, fetch FSM encodings and the
//               {inst, pc} buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int c_XLEN = 32;

    localparam logic c_ENABLE  = 1'b1;
    localparam logic c_DISABLE = 1'b0;

    // Fetch FSM state encodings
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_S_IDLE  = 2'd0;
    localparam fetch_state_t c_S_WAIT  = 2'd1;
    localparam fetch_state_t c_S_DRAIN = 2'd2;

    // One instruction buffer entry: returned word plus the address it came from
    typedef struct packed {
        logic [c_XLEN-1:0] inst;
        logic [c_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry FIFO of {inst, pc} pairs with a single-cycle
//               flush. Head entry is presented combinationally on dout.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               push, din  - write one entry
//               pop        - retire the head entry
//               flush      - discard all entries
//               dout       - head entry
//               count      - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  fetch_entry_t                din,
    output fetch_entry_t                dout,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    fetch_entry_t    r_mem [DEPTH];

    // DEPTH is a power of two, so the natural pointer rollover is modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. Issues one outstanding request at a
//               time to the memory instruction port, buffers returned words
//               with their PC, and hands them to the decoder. Redirects flush
//               the buffer and retarget the PC; a response already in flight
//               at redirect time is discarded (DRAIN state).
// Ports       : clk, rst              - clock, synchronous active-high reset
//               instFree              - memory can accept a request
//               instEn, instAddr      - fetch request pulse and address
//               instOutEn, inst       - memory response pulse and word
//               jumpEn, jumpAddr      - redirect from branch/execute stage
//               stall                 - decoder back-pressure
//               instValid, instOut,   - buffer head presented to decoder
//               instPC
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [31:0]     RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instFree,
    input  logic               instOutEn,
    input  logic [c_XLEN-1:0]  inst,
    output logic               instEn,
    output logic [c_XLEN-1:0]  instAddr,
    input  logic               jumpEn,
    input  logic [c_XLEN-1:0]  jumpAddr,
    input  logic               stall,
    output logic               instValid,
    output logic [c_XLEN-1:0]  instOut,
    output logic [c_XLEN-1:0]  instPC
);

    localparam int                c_CW   = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [c_XLEN-1:0] r_pc;
    logic [c_XLEN-1:0] w_pc_next;
    logic [c_XLEN-1:0] w_jump_target;
    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [c_CW-1:0]   w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_din;
    logic              w_unused_jump_lsbs;

    // Targets are word aligned; the low address bits carry no information.
    assign w_jump_target      = {jumpAddr[c_XLEN-1:2], 2'b00};
    assign w_unused_jump_lsbs = ^jumpAddr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_req        = c_DISABLE;
        w_push       = c_DISABLE;

        // A redirect retargets the PC from every state.
        if (jumpEn) w_pc_next = w_jump_target;

        case (r_state)
            c_S_IDLE: begin
                if (!jumpEn && instFree && (w_count < c_FULL)) begin
                    w_req        = c_ENABLE;
                    w_next_state = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (jumpEn) begin
                    // A response landing with the redirect is simply dropped;
                    // otherwise it is still in flight and must be drained.
                    w_next_state = instOutEn ? c_S_IDLE : c_S_DRAIN;
                end else if (instOutEn) begin
                    w_push       = c_ENABLE;
                    w_pc_next    = r_pc + 32'd4;
                    w_next_state = c_S_IDLE;
                end
            end
            c_S_DRAIN: begin
                if (!jumpEn && instOutEn) w_next_state = c_S_IDLE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    assign w_din   = '{inst: inst, pc: r_pc};
    assign w_valid = (w_count != '0) && !jumpEn && !rst;
    assign w_pop   = w_valid && !stall;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (jumpEn),
        .din   (w_din),
        .dout  (w_head),
        .count (w_count)
    );

    assign instEn    = w_req && !rst;
    assign instAddr  = (w_req && !rst) ? r_pc : '0;
    assign instValid = w_valid;
    assign instOut   = rst ? '0 : w_head.inst;
    assign instPC    = rst ? '0 : w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch: a per-cycle vector table
//               for the directed corner cases, then randomized traffic checked
//               against a transaction-level model (request/response memory,
//               queue of buffered instructions).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        instFree;
    logic        instOutEn;
    logic [31:0] inst;
    logic        instEn;
    logic [31:0] instAddr;
    logic        jumpEn;
    logic [31:0] jumpAddr;
    logic        stall;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] instPC;

    int checks = 0;
    int errors = 0;

    inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instFree  (instFree),
        .instOutEn (instOutEn),
        .inst      (inst),
        .instEn    (instEn),
        .instAddr  (instAddr),
        .jumpEn    (jumpEn),
        .jumpAddr  (jumpAddr),
        .stall     (stall),
        .instValid (instValid),
        .instOut   (instOut),
        .instPC    (instPC)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed per-cycle vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        free;
        logic        oen;
        logic [31:0] inst;
        logic        jen;
        logic [31:0] jaddr;
        logic        stall;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic f, input logic o, input logic [31:0] i,
                                input logic j, input logic [31:0] ja, input logic s,
                                input logic een, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] eo);
        vec_t v;
        v.rst = r; v.free = f; v.oen = o; v.inst = i; v.jen = j; v.jaddr = ja; v.stall = s;
        v.e_en = een; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_out = eo;
        vecs.push_back(v);
    endfunction

    // ------------------------------------------------------------------
    // Random-phase reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
    endfunction

    ent_t        q[$];
    bit          mem_pend;
    bit          killed;
    bit          deliver;
    bit          exp_en;
    bit          exp_valid;
    logic [31:0] mem_addr;
    logic [31:0] exp_req;
    int          mem_timer;
    int          accepted;

    initial begin
        rst = 1'b1; instFree = 1'b0; instOutEn = 1'b0; inst = '0;
        jumpEn = 1'b0; jumpAddr = '0; stall = 1'b0;

        //   rst free oen inst          jen jaddr          stall | en addr          valid pc            out
        add(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h11,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h4,         1, 32'h0,         32'h11);
        add(0, 1, 1, 32'h22,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h4,         32'h22);
        add(0, 1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h8,         1, 32'h4,         32'h22);
        add(0, 1, 1, 32'h33,        0, 32'h0,         1,   0, 32'h0,         1, 32'h4,         32'h22);
        add(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h4,         32'h22);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'h4,         32'h22);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'hC,         1, 32'h8,         32'h33);
        add(0, 1, 0, 32'h0,         1, 32'h103,       0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h44,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h100,       0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h55,        1, 32'hFFFF_FFFE, 0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h66,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h66);
        add(0, 1, 1, 32'h77,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 32'h41,        0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h40,        0, 32'h0,         32'h0);
        add(1, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h88,        0, 32'h0,         0,   1, RESET_PC,      0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h99,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, RESET_PC,      32'h99);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; instFree = vecs[i].free; instOutEn = vecs[i].oen;
            inst = vecs[i].inst; jumpEn = vecs[i].jen; jumpAddr = vecs[i].jaddr;
            stall = vecs[i].stall;
            @(negedge clk);
            check1($sformatf("v%0d instEn", i), instEn, vecs[i].e_en);
            if (vecs[i].e_en || vecs[i].rst)
                check32($sformatf("v%0d instAddr", i), instAddr, vecs[i].e_addr);
            check1($sformatf("v%0d instValid", i), instValid, vecs[i].e_valid);
            if (vecs[i].e_valid || vecs[i].rst) begin
                check32($sformatf("v%0d instPC", i), instPC, vecs[i].e_pc);
                check32($sformatf("v%0d instOut", i), instOut, vecs[i].e_out);
            end
        end

        // Reset before randomized traffic
        @(posedge clk); #1;
        rst = 1'b1; instFree = 1'b0; instOutEn = 1'b0; jumpEn = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        q.delete();
        mem_pend = 0; killed = 0; mem_timer = 0; accepted = 0;
        mem_addr = '0; exp_req = RESET_PC;

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            deliver   = mem_pend && (mem_timer == 0);
            rst       = 1'b0;
            instFree  = ($urandom_range(3) != 0);
            stall     = ($urandom_range(9) < 3);
            instOutEn = deliver;
            inst      = deliver ? word_of(mem_addr) : $urandom();
            // A redirect landing on a drain-state response would strand the
            // fetch unit, so random redirects never coincide with a response.
            jumpEn    = !deliver && ($urandom_range(31) == 0);
            jumpAddr  = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3)))
                                                 : $urandom();
            @(negedge clk);

            exp_en = !mem_pend && instFree && !jumpEn && (q.size() < DEPTH);
            check1("rnd instEn", instEn, exp_en);
            if (instEn && exp_en) check32("rnd instAddr", instAddr, exp_req);

            exp_valid = (q.size() != 0) && !jumpEn;
            check1("rnd instValid", instValid, exp_valid);
            if (instValid && exp_valid) begin
                check32("rnd instPC", instPC, q[0].pc);
                check32("rnd instOut", instOut, q[0].ins);
            end

            if (exp_valid && !stall) begin
                void'(q.pop_front());
                accepted++;
            end
            if (deliver) begin
                if (!killed) begin
                    q.push_back('{pc: mem_addr, ins: word_of(mem_addr)});
                    exp_req = mem_addr + 32'd4;
                end
                mem_pend = 0;
                killed   = 0;
            end else if (mem_pend) begin
                mem_timer--;
            end
            if (jumpEn) begin
                q.delete();
                exp_req = {jumpAddr[31:2], 2'b00};
                if (mem_pend) killed = 1;
            end
            if (exp_en) begin
                mem_pend  = 1;
                mem_addr  = exp_req;
                mem_timer = $urandom_range(3);
            end
        end

        check1("rnd progress", accepted > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
